// File: rtl/adc_read_pkg.sv
// Shared encoding constants, conversion mask and parameter legality helpers
// for the ADC stream capture front-end.
package adc_read_pkg;

    localparam bit ENC_OFFSETBIN = 1'b0;
    localparam bit ENC_TWOSCOMPL = 1'b1;

    // XOR mask that undoes bus inversion and swaps encoding when input and
    // output encodings differ; returned 32 bits wide, caller truncates to W.
    function automatic logic [31:0] conv_mask(int unsigned w, bit inv, bit ienc, bit oenc);
        logic [31:0] m;
        m = inv ? ((32'd1 << w) - 32'd1) : 32'd0;
        if (ienc != oenc) begin
            m = m ^ (32'd1 << (w - 1));
        end
        return m;
    endfunction

    // Width of one channel lane inside the stream word.
    function automatic int unsigned lane_width(int unsigned axis_w, int unsigned ch);
        return (ch == 0) ? axis_w : axis_w / ch;
    endfunction

    function automatic bit params_legal(int unsigned ch, int unsigned w, int unsigned axis_w,
                                        int unsigned d);
        return (ch >= 1) && (ch <= 4) && (w >= 2) && (d <= 8) &&
               ((axis_w % ch) == 0) && ((axis_w / ch) >= w);
    endfunction

endpackage

// File: rtl/adc_stream_read_if.sv
// AXI-Stream style output bundle (data, valid, ready).
interface adc_stream_read_if #(
    parameter int unsigned DW = 32
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/adc_stream_fifo2.sv
// Two-entry stream FIFO. A push that finds the FIFO full with no same-cycle
// pop is dropped and flagged on drop_o; push+pop while full is accepted.
module adc_stream_fifo2 #(
    parameter int unsigned DW = 32
) (
    input  logic          in_clk,
    input  logic          in_rst,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          drop_o
);
    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          empty, full, do_pop, do_push;

    // Occupancy, handshake qualification and next pointers.
    always_comb begin
        empty    = (cnt_q == 2'd0);
        full     = (cnt_q == 2'd2);
        do_pop   = pop_i & ~empty;
        do_push  = push_i & (~full | do_pop);
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        cnt_d    = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        empty_o  = empty;
        full_o   = full;
        drop_o   = push_i & full & ~do_pop;
        // Head word is forced to zero when nothing is buffered.
        dout_o   = empty ? '0 : mem_q[rd_ptr_q];
    end

    // Pointer and occupancy state.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage; contents are don't-care while the slot is not occupied.
    always_ff @(posedge in_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/adc_stream_read.sv
// Multi-channel ADC capture: register pins, undo inversion / re-encode,
// optional 2^D averaging, pack lanes and buffer in a 2-entry stream FIFO.
module adc_stream_read
    import adc_read_pkg::*;
#(
    parameter int unsigned INT_ADC_CHANNELS         = 2,
    parameter int unsigned INT_ADC_DATA_WIDTH       = 14,
    parameter int unsigned INT_AXIS_DATA_WIDTH      = 32,
    parameter int unsigned INT_ADC_DATA_IS_INVERTED = 1,
    parameter int unsigned INT_IDATA_ENC_TWOSCOMPL  = 0,
    parameter int unsigned INT_ODATA_ENC_TWOSCOMPL  = 1,
    parameter int unsigned INT_DECIM_LOG2           = 0
) (
    input  logic                                         in_clk,
    input  logic                                         in_rst,
    input  logic [INT_ADC_CHANNELS*INT_ADC_DATA_WIDTH-1:0] in_data,
    input  logic                                         in_enable,
    input  logic                                         in_clr_overflow,
    adc_stream_read_if.master                            axis,
    output logic                                         out_overflow,
    output logic [31:0]                                  out_sample_cnt
);
    localparam int unsigned CH     = INT_ADC_CHANNELS;
    localparam int unsigned W      = INT_ADC_DATA_WIDTH;
    localparam int unsigned AXIS   = INT_AXIS_DATA_WIDTH;
    localparam int unsigned D      = INT_DECIM_LOG2;
    localparam int unsigned LANE   = lane_width(AXIS, CH);
    localparam int unsigned ACCW   = W + D;
    localparam int unsigned CNTW   = (D == 0) ? 1 : D;
    localparam int unsigned WIN_M1 = (1 << D) - 1;
    localparam bit          OENC   = (INT_ODATA_ENC_TWOSCOMPL != 0);

    localparam logic [W-1:0] MSB     = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] IN_MASK = W'(conv_mask(W, INT_ADC_DATA_IS_INVERTED != 0,
                                                     INT_IDATA_ENC_TWOSCOMPL != 0, OENC));
    // Extra flip so the datapath always carries two's complement.
    localparam logic [W-1:0] INT_FLIP = (OENC == ENC_OFFSETBIN) ? MSB : '0;

    if (!params_legal(CH, W, AXIS, D)) begin : g_param_check
        $error("adc_stream_read: illegal channel/width/decimation parameters");
    end

    logic [CH*W-1:0] cap_data_q;
    logic            cap_en_q;
    logic            conv_vld_q;
    logic [CNTW-1:0] dec_cnt_q, dec_cnt_d;
    logic            dec_last;
    logic            res_vld_q, res_vld_d;
    logic [AXIS-1:0] pack_data;
    logic [AXIS-1:0] fifo_dout;
    logic            fifo_empty, fifo_full, fifo_drop;
    logic            beat;
    logic            overflow_q, overflow_d;
    logic [31:0]     sample_cnt_q, sample_cnt_d;

    // Pin capture; data is deliberately left unreset, only the enable is.
    always_ff @(posedge in_clk) begin
        cap_data_q <= in_data;
    end

    // Qualifier pipeline and decimation window counter.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            cap_en_q   <= 1'b0;
            conv_vld_q <= 1'b0;
            dec_cnt_q  <= '0;
            res_vld_q  <= 1'b0;
        end else begin
            cap_en_q   <= in_enable;
            conv_vld_q <= cap_en_q;
            dec_cnt_q  <= dec_cnt_d;
            res_vld_q  <= res_vld_d;
        end
    end

    // Window bookkeeping: a non-qualified cycle discards the partial window.
    always_comb begin
        dec_last  = (dec_cnt_q == CNTW'(WIN_M1));
        dec_cnt_d = (!conv_vld_q || dec_last) ? '0 : dec_cnt_q + CNTW'(1);
        res_vld_d = conv_vld_q & dec_last;
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic signed [W-1:0]    conv_q;
        logic signed [ACCW-1:0] conv_ext, acc_sum, acc_q, acc_d;
        logic        [W-1:0]    res_q, res_d;

        // Inversion/encoding fix-up into two's complement.
        always_ff @(posedge in_clk) begin
            conv_q <= $signed(cap_data_q[i*W +: W] ^ IN_MASK ^ INT_FLIP);
        end

        // Accumulate the window; on its last sample emit floor(sum / 2^D).
        always_comb begin
            conv_ext = ACCW'(conv_q);
            acc_sum  = acc_q + conv_ext;
            acc_d    = (conv_vld_q && !dec_last) ? acc_sum : '0;
            res_d    = (conv_vld_q && dec_last) ? W'(acc_sum >>> D) : res_q;
        end

        // Accumulator and result registers.
        always_ff @(posedge in_clk) begin
            if (in_rst) begin
                acc_q <= '0;
                res_q <= '0;
            end else begin
                acc_q <= acc_d;
                res_q <= res_d;
            end
        end

        if (OENC == ENC_TWOSCOMPL) begin : g_twos
            assign pack_data[i*LANE +: LANE] = LANE'($signed(res_q));
        end else begin : g_offs
            assign pack_data[i*LANE +: LANE] = LANE'(res_q ^ MSB);
        end
    end

    adc_stream_fifo2 #(
        .DW (AXIS)
    ) u_fifo (
        .in_clk  (in_clk),
        .in_rst  (in_rst),
        .push_i  (res_vld_q),
        .din_i   (pack_data),
        .pop_i   (beat),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .drop_o  (fifo_drop)
    );

    assign axis.tdata  = fifo_dout;
    assign axis.tvalid = ~fifo_empty;
    assign beat        = ~fifo_empty & axis.tready;

    // Sticky overflow (set beats clear) and accepted-beat counter.
    always_comb begin
        overflow_d   = fifo_drop ? 1'b1 : (in_clr_overflow ? 1'b0 : overflow_q);
        sample_cnt_d = sample_cnt_q + {31'd0, beat};
    end

    // Status registers.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            overflow_q   <= 1'b0;
            sample_cnt_q <= 32'd0;
        end else begin
            overflow_q   <= overflow_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign out_overflow   = overflow_q;
    assign out_sample_cnt = sample_cnt_q;

    a_drop_only_when_full: assert property (@(posedge in_clk) disable iff (in_rst)
        fifo_drop |-> fifo_full);

endmodule
